// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET   = 32'd8;
  localparam logic [31:0] NOP              = 32'hE1A0_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: hazard/redirect controls, instruction memory port and IF/ID outputs.
interface instruction_fetch_if;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus8;

  modport master (
    input  stall, branch_valid, branch_target, imem_data,
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus8
  );

  modport slave (
    output stall, branch_valid, branch_target, imem_data,
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus8
  );
endinterface

// File: rtl/fetch_perf_counters.sv
// Fetch and squash event counters; only built when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        nreset,
  input  logic        i_fetch_inc,
  input  logic        i_squash_inc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_squash_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_squash_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_fetch_cnt  <= 32'd0;
      r_squash_cnt <= 32'd0;
    end else begin
      if (i_fetch_inc)  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (i_squash_inc) r_squash_cnt <= r_squash_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_squash_cnt = r_squash_cnt;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, stall and branch redirect.
// Optional perf counters are enabled with the FETCH_PERF_CNT_EN macro.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        nreset,
  instruction_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_squash_cnt
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic         w_redirect;
  logic         w_load;

  logic [31:0]  r_pc;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_pc_plus8;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= BOOT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Redirect wins over stall; nothing moves during the BOOT cycle.
  always_comb begin
    w_redirect = 1'b0;
    w_load     = 1'b0;
    if (r_state == RUN) begin
      w_redirect = bus.branch_valid;
      w_load     = !bus.branch_valid && !bus.stall;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'd0;
      r_if_pc       <= 32'd0;
      r_if_pc_plus8 <= 32'd0;
    end else if (w_redirect) begin
      r_pc       <= bus.branch_target & ~32'd3;
      r_if_valid <= 1'b0;
    end else if (w_load) begin
      r_pc          <= r_pc + PC_STEP;
      r_if_valid    <= 1'b1;
      r_if_instr    <= bus.imem_data;
      r_if_pc       <= r_pc;
      r_if_pc_plus8 <= r_pc + PC_READ_OFFSET;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_instr    = r_if_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus8 = r_if_pc_plus8;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk          (clk),
    .nreset       (nreset),
    .i_fetch_inc  (w_load),
    .i_squash_inc (w_redirect),
    .o_fetch_cnt  (perf_fetch_cnt),
    .o_squash_cnt (perf_squash_cnt)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic against a fetch-stream model.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if bus();
  instruction_fetch_if bus_w();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_squash_cnt, perf_fetch_cnt_w, perf_squash_cnt_w;
`endif

  instruction_fetch #(.RESET_PC(RESET_PC_DEFAULT)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_squash_cnt (perf_squash_cnt)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus_w)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt_w),
    .perf_squash_cnt (perf_squash_cnt_w)
`endif
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ NOP;
  endfunction

  assign bus.imem_data   = imem_word(bus.imem_addr);
  assign bus_w.imem_data = imem_word(bus_w.imem_addr);

  int nvec = 0;
  int nerr = 0;

  // Reference: architectural view of the fetch stream
  logic [31:0] m_pc, m_instr, m_ifpc, m_pc8, m_fcnt, m_scnt;
  logic        m_valid;
  bit          m_boot;

  function automatic logic [128:0] got_vec();
    return {bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus8};
  endfunction

  function automatic logic [128:0] exp_vec();
    return {m_pc, m_valid, m_instr, m_ifpc, m_pc8};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC_DEFAULT; m_valid = 1'b0; m_instr = '0; m_ifpc = '0; m_pc8 = '0;
    m_boot = 1'b1; m_fcnt = '0; m_scnt = '0;
  endtask

  task automatic reset_assert();
    @(posedge clk);
    #3 nreset = 1'b0;
    #1 model_reset();
  endtask

  task automatic reset_release();
    bus.stall = 1'b0; bus.branch_valid = 1'b0; bus.branch_target = '0;
    @(posedge clk);
    @(posedge clk);
    #2 nreset = 1'b1;
  endtask

  task automatic step(input logic st, input logic bv, input logic [31:0] bt);
    @(negedge clk);
    bus.stall = st; bus.branch_valid = bv; bus.branch_target = bt;
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (bv) begin
      m_pc = {bt[31:2], 2'b00};
      m_valid = 1'b0;
      m_scnt++;
    end else if (!st) begin
      m_instr = imem_word(m_pc);
      m_ifpc  = m_pc;
      m_pc8   = m_pc + 32'd8;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_fcnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_assert();
    nvec++;
    if (got_vec() !== {RESET_PC_DEFAULT, 97'd0}) begin
      nerr++; $display("FAIL reset_vals got %h exp %h", got_vec(), {RESET_PC_DEFAULT, 97'd0});
    end
    nvec++;
    if (bus_w.imem_addr !== 32'hFFFF_FFF8) begin
      nerr++; $display("FAIL reset_pc_w got %h exp %h", bus_w.imem_addr, 32'hFFFF_FFF8);
    end
    reset_release();
    step(1'b1, 1'b1, 32'h0000_1234);
    nvec++;
    if (got_vec() !== exp_vec() || bus.if_valid !== 1'b0 || bus.imem_addr !== 32'd0) begin
      nerr++; $display("FAIL boot_ignore got %h exp %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0);
      nvec++;
      if (got_vec() !== exp_vec() || bus.if_pc !== 32'(i * 4) || bus.if_pc_plus8 !== 32'(i * 4 + 8)) begin
        nerr++; $display("FAIL seq%0d got %h exp %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc;
    reset_assert(); reset_release();
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    held_pc = bus.if_pc;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0);
      nvec++;
      if (got_vec() !== exp_vec() || bus.imem_addr !== 32'h10 || bus.if_pc !== 32'h0C) begin
        nerr++; $display("FAIL stall%0d got %h exp %h held_pc %h", i, got_vec(), exp_vec(), held_pc);
      end
    end
    step(1'b0, 1'b0, '0);
    nvec++;
    if (got_vec() !== exp_vec() || bus.if_pc !== 32'h10 || bus.if_valid !== 1'b1) begin
      nerr++; $display("FAIL stall_resume got %h exp %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_branch();
    reset_assert(); reset_release();
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h23);
    nvec++;
    if (got_vec() !== exp_vec() || bus.imem_addr !== 32'h20 || bus.if_valid !== 1'b0) begin
      nerr++; $display("FAIL branch_bubble got %h exp %h", got_vec(), exp_vec());
    end
    step(1'b0, 1'b0, '0);
    nvec++;
    if (got_vec() !== exp_vec() || bus.if_pc !== 32'h20 || bus.if_valid !== 1'b1) begin
      nerr++; $display("FAIL branch_target got %h exp %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_branch_stall();
    step(1'b1, 1'b1, 32'h107);
    nvec++;
    if (got_vec() !== exp_vec() || bus.imem_addr !== 32'h104 || bus.if_valid !== 1'b0) begin
      nerr++; $display("FAIL br_stall got %h exp %h", got_vec(), exp_vec());
    end
    step(1'b0, 1'b0, '0);
    nvec++;
    if (got_vec() !== exp_vec() || bus.if_pc !== 32'h104) begin
      nerr++; $display("FAIL br_stall_tgt got %h exp %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    logic        exp_v  [4];
    exp_pc = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    exp_v  = '{1'b0, 1'b1, 1'b1, 1'b1};
    reset_assert(); reset_release();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      nvec++;
      if (bus_w.if_valid !== exp_v[i] || bus_w.if_pc !== exp_pc[i] ||
          (exp_v[i] && (bus_w.if_pc_plus8 !== exp_pc[i] + 32'd8 || bus_w.if_instr !== imem_word(exp_pc[i])))) begin
        nerr++; $display("FAIL wrap%0d got v=%b pc=%h pc8=%h exp v=%b pc=%h", i,
                         bus_w.if_valid, bus_w.if_pc, bus_w.if_pc_plus8, exp_v[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_reset_mid_redirect();
    reset_assert(); reset_release();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    bus.branch_valid = 1'b1; bus.branch_target = 32'h40;
    #2 nreset = 1'b0;
    #1 model_reset();
    nvec++;
    if (got_vec() !== {RESET_PC_DEFAULT, 97'd0}) begin
      nerr++; $display("FAIL mid_reset got %h exp %h", got_vec(), {RESET_PC_DEFAULT, 97'd0});
    end
`ifdef FETCH_PERF_CNT_EN
    nvec++;
    if (perf_fetch_cnt !== 32'd0 || perf_squash_cnt !== 32'd0) begin
      nerr++; $display("FAIL mid_reset_cnt got %h %h exp 0 0", perf_fetch_cnt, perf_squash_cnt);
    end
`endif
    reset_release();
    step(1'b0, 1'b1, 32'h80);
    step(1'b0, 1'b0, '0);
    nvec++;
    if (got_vec() !== exp_vec() || bus.if_pc !== RESET_PC_DEFAULT || bus.if_valid !== 1'b1) begin
      nerr++; $display("FAIL post_reset got %h exp %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic st, bv;
    logic [31:0] bt;
    reset_assert(); reset_release();
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 3) == 0);
      bv = ($urandom_range(0, 6) == 0);
      bt = $urandom;
      step(st, bv, bt);
      nvec++;
      if (got_vec() !== exp_vec()) begin
        nerr++; $display("FAIL rand%0d st=%b bv=%b got %h exp %h", i, st, bv, got_vec(), exp_vec());
      end
`ifdef FETCH_PERF_CNT_EN
      nvec++;
      if (perf_fetch_cnt !== m_fcnt || perf_squash_cnt !== m_scnt) begin
        nerr++; $display("FAIL rand_cnt%0d got %h %h exp %h %h", i, perf_fetch_cnt, perf_squash_cnt, m_fcnt, m_scnt);
      end
`endif
    end
  endtask

  initial begin
    bus.stall = 1'b0; bus.branch_valid = 1'b0; bus.branch_target = '0;
    bus_w.stall = 1'b0; bus_w.branch_valid = 1'b0; bus_w.branch_target = '0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_reset_mid_redirect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
